// File: rtl/wb_arbiter_pkg.sv
// Shared CPU write-back types: the register-file write record and the hard-wired zero register.
package wb_arbiter_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order queue of pending MDU write-backs with per-entry address match and kill.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter int  NCMP  = 3,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wb_req_t          push_req,
  input  logic             pop,
  output wb_req_t          head,
  output logic             head_live,
  output logic [CW-1:0]    count,
  input  logic [4:0]       cmp_addr [NCMP],
  output logic [DEPTH-1:0] hit [NCMP],
  input  logic [DEPTH-1:0] kill
);

  wb_req_t          mem [DEPTH];
  logic [DEPTH-1:0] valid_reg, valid_next;
  logic [DEPTH-1:0] killed_reg, killed_next;
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  // A push re-arms its slot, so a kill aimed at the same slot in the same cycle is overridden.
  always_comb begin
    valid_next  = valid_reg;
    killed_next = killed_reg | kill;
    if (pop) begin
      valid_next[rd_ptr_reg]  = 1'b0;
      killed_next[rd_ptr_reg] = 1'b0;
    end
    if (push) begin
      valid_next[wr_ptr_reg]  = 1'b1;
      killed_next[wr_ptr_reg] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg  <= '0;
      killed_reg <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      valid_reg  <= valid_next;
      killed_reg <= killed_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg  <= count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_req;
  end

  assign head      = mem[rd_ptr_reg];
  assign head_live = valid_reg[rd_ptr_reg] & ~killed_reg[rd_ptr_reg];
  assign count     = count_reg;

  generate
    for (genvar gi = 0; gi < NCMP; gi++) begin : g_cmp
      for (genvar gj = 0; gj < DEPTH; gj++) begin : g_ent
        assign hit[gi][gj] = valid_reg[gj] & ~killed_reg[gj] & (mem[gj].addr == cmp_addr[gi]);
      end
    end
  endgenerate

endmodule

// File: rtl/wb_arbiter.sv
// Single register-file write port shared by the W-stage pipe (priority) and a queued MDU result stream.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int QDEPTH     = 2,
  parameter int STARVE_LIM = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_wen,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  input  logic [31:0] pipe_pc,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  input  logic [31:0] mdu_pc,
  output logic        mdu_ready,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  output logic        pend1,
  output logic        pend2,
  output logic        hold_pipe,
  output logic        grf_wen,
  output logic [4:0]  grf_addr,
  output logic [31:0] grf_data,
  output logic [31:0] grf_pc
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIM + 1);

  logic [CW-1:0]     count;
  wb_req_t           head, pipe_req, mdu_req;
  wb_req_t           grf_req_reg, grf_req_next;
  logic              grf_wen_reg, grf_wen_next;
  logic              head_live, transfer, push, pop, q_busy, waiting;
  logic [4:0]        cmp_addr [3];
  logic [QDEPTH-1:0] hit [3];
  logic [QDEPTH-1:0] kill;
  logic [SW-1:0]     starve_reg, starve_next;

  assign pipe_req  = '{addr: pipe_addr, data: pipe_data, pc: pipe_pc};
  assign mdu_req   = '{addr: mdu_addr, data: mdu_data, pc: mdu_pc};
  assign q_busy    = (count != '0);
  assign mdu_ready = (count < CW'(QDEPTH));
  assign transfer  = mdu_valid & mdu_ready;
  assign pop       = ~pipe_wen & q_busy;
  // Zero-address results complete the handshake but never take a slot.
  assign push      = transfer & (mdu_addr != REG_ZERO) & (pipe_wen | q_busy);

  assign cmp_addr[0] = rd_addr1;
  assign cmp_addr[1] = rd_addr2;
  assign cmp_addr[2] = pipe_addr;
  // The pipe write is younger than anything queued, so older results to its register must die.
  assign kill  = (pipe_wen && pipe_addr != REG_ZERO) ? hit[2] : '0;
  assign pend1 = (rd_addr1 != REG_ZERO) & (|hit[0]);
  assign pend2 = (rd_addr2 != REG_ZERO) & (|hit[1]);

  wb_fifo #(.DEPTH(QDEPTH), .NCMP(3)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_req  (mdu_req),
    .pop       (pop),
    .head      (head),
    .head_live (head_live),
    .count     (count),
    .cmp_addr  (cmp_addr),
    .hit       (hit),
    .kill      (kill)
  );

  always_comb begin
    grf_req_next = grf_req_reg;
    grf_wen_next = 1'b0;
    if (pipe_wen) begin
      grf_req_next = pipe_req;
      grf_wen_next = (pipe_addr != REG_ZERO);
    end else if (q_busy) begin
      grf_req_next = head;
      grf_wen_next = head_live;
    end else if (transfer) begin
      grf_req_next = mdu_req;
      grf_wen_next = (mdu_addr != REG_ZERO);
    end
  end

  // An entry pushed this cycle is already being blocked by the pipe write, so it counts as waiting.
  assign waiting = q_busy | push;

  always_comb begin
    starve_next = starve_reg;
    if (pop || !waiting)
      starve_next = '0;
    else if (pipe_wen && starve_reg != SW'(STARVE_LIM))
      starve_next = starve_reg + SW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grf_req_reg <= '0;
      grf_wen_reg <= 1'b0;
      starve_reg  <= '0;
    end else begin
      grf_req_reg <= grf_req_next;
      grf_wen_reg <= grf_wen_next;
      starve_reg  <= starve_next;
    end
  end

  assign hold_pipe = (starve_reg == SW'(STARVE_LIM));
  assign grf_wen   = grf_wen_reg;
  assign grf_addr  = grf_req_reg.addr;
  assign grf_data  = grf_req_reg.data;
  assign grf_pc    = grf_req_reg.pc;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: bypass, priority, full/starvation, kill, zero register, async reset.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_wen;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data, pipe_pc;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data, mdu_pc;
  logic        mdu_ready;
  logic [4:0]  rd_addr1, rd_addr2;
  logic        pend1, pend2, hold_pipe;
  logic        grf_wen;
  logic [4:0]  grf_addr;
  logic [31:0] grf_data, grf_pc;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rf [32];

  always #5 clk = ~clk;

  wb_arbiter #(.QDEPTH(2), .STARVE_LIM(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .pipe_wen  (pipe_wen),
    .pipe_addr (pipe_addr),
    .pipe_data (pipe_data),
    .pipe_pc   (pipe_pc),
    .mdu_valid (mdu_valid),
    .mdu_addr  (mdu_addr),
    .mdu_data  (mdu_data),
    .mdu_pc    (mdu_pc),
    .mdu_ready (mdu_ready),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .pend1     (pend1),
    .pend2     (pend2),
    .hold_pipe (hold_pipe),
    .grf_wen   (grf_wen),
    .grf_addr  (grf_addr),
    .grf_data  (grf_data),
    .grf_pc    (grf_pc)
  );

  // Shadow register file built from observed writes; also flags pipe writes issued under hold.
  always @(negedge clk) begin
    if (reset && grf_wen) rf[grf_addr] = grf_data;
    if (reset && pipe_wen && hold_pipe)
      $display("note: protocol violation, pipe_wen while hold_pipe at %0t", $time);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_wen  = 1'b0;
    mdu_valid = 1'b0;
  endtask

  task automatic pipe(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    pipe_wen = 1'b1; pipe_addr = a; pipe_data = d; pipe_pc = pc;
  endtask

  task automatic mdu(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    mdu_valid = 1'b1; mdu_addr = a; mdu_data = d; mdu_pc = pc;
  endtask

  task automatic expect_write(input string tag, input logic [4:0] a, input logic [31:0] d);
    check({tag, ".wen"},  32'(grf_wen), 32'd1);
    check({tag, ".addr"}, 32'(grf_addr), 32'(a));
    check({tag, ".data"}, grf_data, d);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    reset = 1'b0;
    pipe_wen = 0; pipe_addr = 0; pipe_data = 0; pipe_pc = 0;
    mdu_valid = 0; mdu_addr = 0; mdu_data = 0; mdu_pc = 0;
    rd_addr1 = 5'd5; rd_addr2 = 5'd0;

    // Reset state
    #3;
    check("rst.grf_wen",   32'(grf_wen),   32'd0);
    check("rst.grf_addr",  32'(grf_addr),  32'd0);
    check("rst.grf_data",  grf_data,       32'd0);
    check("rst.mdu_ready", 32'(mdu_ready), 32'd1);
    check("rst.hold",      32'(hold_pipe), 32'd0);
    check("rst.pend1",     32'(pend1),     32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Bypass
    mdu(5'd5, 32'h1234, 32'h3000);
    tick();
    idle();
    #1;
    expect_write("byp", 5'd5, 32'h1234);
    check("byp.pc",    grf_pc,          32'h3000);
    check("byp.pend1", 32'(pend1),      32'd0);
    check("byp.ready", 32'(mdu_ready),  32'd1);
    tick();
    check("byp.after_wen", 32'(grf_wen), 32'd0);

    // Priority: pipe first, MDU follows from the queue
    pipe(5'd3, 32'hAAAA, 32'h100);
    mdu(5'd4, 32'hBBBB, 32'h200);
    tick();
    idle();
    rd_addr1 = 5'd4;
    #1;
    expect_write("pri.c1", 5'd3, 32'hAAAA);
    check("pri.pend1", 32'(pend1), 32'd1);
    tick();
    expect_write("pri.c2", 5'd4, 32'hBBBB);
    check("pri.pend1_clr", 32'(pend1), 32'd0);
    tick();

    // Full queue and starvation
    pipe(5'd1, 32'hA1, 32'h10); mdu(5'd12, 32'hC1, 32'h50);
    check("full.c0.ready", 32'(mdu_ready), 32'd1);
    tick();
    expect_write("full.c1", 5'd1, 32'hA1);
    check("full.c1.ready", 32'(mdu_ready), 32'd1);
    pipe(5'd2, 32'hA2, 32'h14); mdu(5'd13, 32'hC2, 32'h54);
    tick();
    check("full.c2.ready", 32'(mdu_ready), 32'd0);
    check("full.c2.hold",  32'(hold_pipe), 32'd0);
    pipe(5'd3, 32'hA3, 32'h18); mdu(5'd14, 32'hC3, 32'h58);
    tick();
    check("full.c3.ready", 32'(mdu_ready), 32'd0);
    check("full.c3.hold",  32'(hold_pipe), 32'd1);
    pipe(5'd4, 32'hA4, 32'h1C);
    tick();
    check("full.c4.hold",  32'(hold_pipe), 32'd1);
    pipe(5'd5, 32'hA5, 32'h20);
    tick();
    expect_write("full.c5", 5'd5, 32'hA5);
    check("full.c5.ready", 32'(mdu_ready), 32'd0);
    pipe_wen = 1'b0;
    tick();
    expect_write("full.c6", 5'd12, 32'hC1);
    check("full.c6.hold",  32'(hold_pipe), 32'd0);
    check("full.c6.ready", 32'(mdu_ready), 32'd1);
    tick();
    expect_write("full.c7", 5'd13, 32'hC2);
    mdu_valid = 1'b0;
    tick();
    expect_write("full.c8", 5'd14, 32'hC3);
    tick();
    check("full.c9.wen", 32'(grf_wen), 32'd0);

    // Kill: younger pipe write supersedes a queued MDU result
    pipe(5'd1, 32'h11, 32'h60); mdu(5'd7, 32'h77, 32'h64);
    tick();
    mdu_valid = 1'b0;
    rd_addr2 = 5'd7;
    #1;
    check("kill.pend2_set", 32'(pend2), 32'd1);
    pipe(5'd7, 32'h700, 32'h68);
    tick();
    idle();
    #1;
    expect_write("kill.pipe", 5'd7, 32'h700);
    check("kill.pend2_clr", 32'(pend2), 32'd0);
    tick();
    check("kill.deq_wen", 32'(grf_wen),   32'd0);
    check("kill.ready",   32'(mdu_ready), 32'd1);
    tick();
    check("kill.rf7", rf[7], 32'h700);

    // Zero register from both sources
    pipe(5'd0, 32'hDEAD, 32'h70);
    tick();
    idle();
    check("zero.pipe_wen",  32'(grf_wen),   32'd0);
    check("zero.ready0",    32'(mdu_ready), 32'd1);
    mdu(5'd0, 32'hBEEF, 32'h74);
    #1;
    check("zero.ready1",    32'(mdu_ready), 32'd1);
    tick();
    mdu_valid = 1'b0;
    check("zero.mdu_wen",   32'(grf_wen),   32'd0);
    check("zero.ready2",    32'(mdu_ready), 32'd1);
    tick();
    check("zero.after_wen", 32'(grf_wen),   32'd0);

    // Asynchronous reset with two queued entries
    rd_addr1 = 5'd9;
    pipe(5'd20, 32'h2020, 32'h80); mdu(5'd9, 32'h99, 32'h84);
    tick();
    pipe(5'd21, 32'h2121, 32'h88); mdu(5'd10, 32'hAA, 32'h8C);
    tick();
    check("ar.full_ready", 32'(mdu_ready), 32'd0);
    check("ar.pend1",      32'(pend1),     32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ar.grf_wen",   32'(grf_wen),   32'd0);
    check("ar.ready",     32'(mdu_ready), 32'd1);
    check("ar.pend1_clr", 32'(pend1),     32'd0);
    check("ar.hold",      32'(hold_pipe), 32'd0);
    idle();
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ar.post%0d_wen", i), 32'(grf_wen), 32'd0);
    end
    pipe(5'd11, 32'hB0B, 32'h90);
    tick();
    idle();
    expect_write("ar.first", 5'd11, 32'hB0B);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter QDEPTH, default 2: MDU result queue depth in entries; legal values 2 or 4.
REQ-002 Parameter STARVE_LIM, default 3: number of consecutive cycles the pipe write may block a waiting queue before hold_pipe asserts.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-low; 0 resets all state immediately.
REQ-005 pipe_wen  in  1  W-stage write request; always accepted, never back-pressured.
REQ-006 pipe_addr / pipe_data / pipe_pc  in  5/32/32  W-stage destination register, write data, and instruction PC.
REQ-007 mdu_valid  in  1  multi-cycle unit result valid.
REQ-008 mdu_addr / mdu_data / mdu_pc  in  5/32/32  MDU destination register, write data, and instruction PC.
REQ-009 mdu_ready  out  1  MDU handshake ready; a transfer occurs when mdu_valid and mdu_ready are both 1.
REQ-010 rd_addr1 / rd_addr2  in  5/5  D-stage source register addresses.
REQ-011 pend1 / pend2  out  1/1  a queued MDU write targets rd_addr1 / rd_addr2.
REQ-012 hold_pipe  out  1  request for the pipeline to withhold pipe_wen.
REQ-013 grf_wen / grf_addr / grf_data / grf_pc  out  1/5/32/32  single register-file write port.

Function
REQ-014 The write-port outputs shall be registered; a pipe write on cycle t shall appear on grf_* during cycle t+1.
REQ-015 The pipe write shall have priority over the MDU for the write port in every cycle.
REQ-016 An MDU transfer in a cycle with pipe_wen=0 and an empty queue shall bypass the queue and drive grf_* during cycle t+1.
REQ-017 Any other MDU transfer shall be enqueued in arrival order.
REQ-018 In a cycle with pipe_wen=0 and a non-empty queue, the queue head shall dequeue to grf_* on the next cycle; a bypass shall not occur in that cycle, and any new transfer shall enqueue.
REQ-019 mdu_ready shall equal (count < QDEPTH), decoded from registered count.
REQ-020 When the queue is full, simultaneous dequeue and arrival shall not be accepted; mdu_ready stays 0 for that cycle.
REQ-021 Requests with address 0 (pipe or MDU) shall be consumed without a queue entry and without asserting grf_wen; the MDU handshake still completes.
REQ-022 Ordering: a pipe write to address A shall invalidate every queued entry with address A, because the pipe write is younger.
REQ-023 Invalidated entries shall still occupy their slots and dequeue silently with grf_wen=0.
REQ-024 pend1 shall be 1 iff rd_addr1 != 0 and some valid, un-invalidated queue entry has address rd_addr1; it is combinational and excludes the grf_* register. pend2 follows the same rule for rd_addr2.
REQ-025 The starvation counter shall increment each cycle that the queue is non-empty and pipe_wen=1.
REQ-026 The starvation counter shall clear on any dequeue or when the queue is empty, and shall saturate at STARVE_LIM.
REQ-027 hold_pipe shall be 1 iff counter == STARVE_LIM.
REQ-028 A pipe_wen arriving while hold_pipe=1 shall still be accepted per REQ-015; it is a protocol violation that the bench flags.
REQ-029 Queue pointers shall be log2(QDEPTH) bits, wrap modulo QDEPTH, and count shall be log2(QDEPTH)+1 bits.

Reset
REQ-030 On reset=0: count, pointers, valid and invalidate bits, and the starvation counter shall be 0; grf_wen=0 and grf_addr/grf_data/grf_pc=0; hold_pipe=0.
REQ-031 During reset, mdu_ready shall be 1 and pend1/pend2 shall be 0.
REQ-032 Reset asserted mid-operation shall discard queued entries without emitting writes.
REQ-033 The first write after reset deassertion shall be the first post-reset request accepted.

Structure
REQ-034 The write-request record {addr[4:0], data[31:0], pc[31:0]} shall be a typedef in the shared CPU package, together with the REG_ZERO constant 5'd0.
REQ-035 The queue shall be a single sub-module wb_fifo providing push, pop, head, a per-entry address-match vector, and per-entry kill; the arbitration and starvation logic stays in wb_arbiter.

Verification
REQ-036 Bypass: idle block, MDU transfer {addr 5, data 0x1234, pc 0x3000} on cycle 0 -> cycle 1 grf_wen=1, grf_addr=5, grf_data=0x1234, grf_pc=0x3000; queue stays empty.
REQ-037 Priority: pipe {addr 3, 0xAAAA} and MDU {addr 4, 0xBBBB} on cycle 0 -> cycle 1 writes addr 3; cycle 2 writes addr 4; pend1=1 during cycle 1 with rd_addr1=4.
REQ-038 Full and starvation: pipe_wen held high for 5 cycles while the MDU offers 3 results -> mdu_ready=0 after 2 acceptances; hold_pipe=1 from cycle 3; results drain in order once pipe_wen drops.
REQ-039 Kill: MDU addr 7 queued, then pipe write addr 7 -> pend for addr 7 drops next cycle; the dequeue of that entry produces grf_wen=0; the register file retains the pipe value.
REQ-040 Zero register: pipe addr 0 and MDU addr 0 on separate cycles -> grf_wen stays 0; mdu_ready stays 1 throughout.
REQ-041 Async reset: queue holding 2 entries, reset pulsed low between clock edges -> grf_wen=0 and mdu_ready=1 immediately; no queued write appears after release.
